avr_pool_sched: RTL and testbench

Scheduler that sequences the unrolled average/max pooling unit across a feature map held in a word-wide line memory. It accepts one job configuration, fetches 8-pixel words row-group by row-group, and drives the pooling unit's start/en/data handshake. It collects each o_pool result on done and forwards it on a valid/ready output stream. It sits between the job-control block, the feature-map RAM and the pooling datapath.

---
 rtl/avr_pool_sched_if.sv | 53 +++++
 rtl/avr_pool_sched.sv | 193 +++++++++++++++++++
 tb/tb_avr_pool_sched.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_pool_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : avr_pool_sched_if
// Brief    : Job config, line-memory read, pooling-unit and result-stream
//            signals of the pooling scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface avr_pool_sched_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 8
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [ADDR_W-1:0]   cfg_base;
    logic [DIM_W-1:0]    cfg_wpr;
    logic [DIM_W-1:0]    cfg_rows;
    logic                cfg_size;
    logic                cfg_pool_sel;
    logic                mem_re;
    logic [ADDR_W-1:0]   mem_addr;
    logic [8*DATA_W-1:0] mem_rdata;
    logic                start;
    logic                en;
    logic                size1;
    logic                size2;
    logic                pool_sel;
    logic [8*DATA_W-1:0] pool_d;
    logic                done;
    logic [4*DATA_W-1:0] pool_o;
    logic                out_valid;
    logic                out_ready;
    logic [4*DATA_W-1:0] out_data;
    logic [2:0]          out_cnt;
    logic                out_last;
    logic                busy;
    logic                err;

    modport master (
        input  cfg_valid, cfg_base, cfg_wpr, cfg_rows, cfg_size, cfg_pool_sel,
               mem_rdata, done, pool_o, out_ready,
        output cfg_ready, mem_re, mem_addr, start, en, size1, size2, pool_sel,
               pool_d, out_valid, out_data, out_cnt, out_last, busy, err
    );

    modport slave (
        output cfg_valid, cfg_base, cfg_wpr, cfg_rows, cfg_size, cfg_pool_sel,
               mem_rdata, done, pool_o, out_ready,
        input  cfg_ready, mem_re, mem_addr, start, en, size1, size2, pool_sel,
               pool_d, out_valid, out_data, out_cnt, out_last, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/avr_pool_sched.sv
`default_nettype none
// ============================================================================
// Module   : avr_pool_sched
// Brief    : Walks a feature map window by window, feeding 8-pixel words to
//            the pooling unit and streaming its results out.
// Revision : 1.0 - initial release
// ============================================================================
module avr_pool_sched #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int DIM_W    = 8,
    parameter int DONE_TMO = 64
) (
    input  wire logic         clk,
    input  wire logic         rst_fsm,
    avr_pool_sched_if.master  bus
);
    localparam int                 c_tmo_w   = $clog2(DONE_TMO + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(DONE_TMO);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_row_base;
    logic [ADDR_W-1:0]   r_addr;
    logic [DIM_W-1:0]    r_wpr;
    logic [DIM_W-1:0]    r_rows;
    logic [DIM_W-1:0]    r_col;
    logic [DIM_W-1:0]    r_grp;
    logic [1:0]          r_beat;
    logic [c_tmo_w-1:0]  r_tmo;
    logic                r_size;
    logic                r_pool_sel;
    logic                r_err_cfg;
    logic [4*DATA_W-1:0] r_out_data;

    logic                w_cfg_bad;
    logic [DIM_W+1:0]    w_kwpr_full;
    logic [ADDR_W-1:0]   w_kwpr;
    logic [ADDR_W-1:0]   w_wpr_ext;
    logic [ADDR_W-1:0]   w_beat0_addr;
    logic [DIM_W-1:0]    w_ngrp;
    logic [1:0]          w_last_beat;
    logic                w_last_col;
    logic                w_last_win;
    logic                w_tmo;
    logic                w_mem_re;
    logic                w_start;
    logic                w_en;
    logic                w_busy;
    logic                w_emit;

    assign w_cfg_bad    = (bus.cfg_wpr == '0) || (bus.cfg_rows == '0) ||
                          (bus.cfg_size ? (bus.cfg_rows[1:0] != 2'b00) : bus.cfg_rows[0]);
    // K*wpr row-group stride via shift: the next group starts K rows further on
    assign w_kwpr_full  = r_size ? {r_wpr, 2'b00} : {1'b0, r_wpr, 1'b0};
    assign w_kwpr       = ADDR_W'(w_kwpr_full);
    assign w_wpr_ext    = ADDR_W'(r_wpr);
    assign w_beat0_addr = r_row_base + ADDR_W'(r_col);
    assign w_ngrp       = r_size ? (r_rows >> 2) : (r_rows >> 1);
    assign w_last_beat  = r_size ? 2'd3 : 2'd1;
    assign w_last_col   = (r_col == r_wpr - DIM_W'(1));
    assign w_last_win   = w_last_col && (r_grp == w_ngrp - DIM_W'(1));
    assign w_tmo        = (r_state == S_WAIT) && !bus.done && (r_tmo == c_tmo_max);
    assign w_busy       = (r_state != S_IDLE);
    assign w_emit       = (r_state == S_EMIT);

    always_comb begin
        w_next   = r_state;
        w_mem_re = 1'b0;
        w_start  = 1'b0;
        w_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cfg_valid && !w_cfg_bad)
                    w_next = S_START;
            end
            S_START: begin
                w_start  = 1'b1;
                w_mem_re = 1'b1;
                w_next   = S_FEED;
            end
            S_FEED: begin
                w_en = 1'b1;
                if (r_beat == w_last_beat)
                    w_next = S_WAIT;
                else
                    w_mem_re = 1'b1;
            end
            S_WAIT: begin
                if (bus.done)
                    w_next = S_EMIT;
                else if (w_tmo)
                    w_next = S_IDLE;
            end
            S_EMIT: begin
                if (bus.out_ready)
                    w_next = w_last_win ? S_IDLE : S_START;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_fsm) begin
            r_state    <= S_IDLE;
            r_row_base <= '0;
            r_addr     <= '0;
            r_wpr      <= '0;
            r_rows     <= '0;
            r_col      <= '0;
            r_grp      <= '0;
            r_beat     <= '0;
            r_tmo      <= '0;
            r_size     <= 1'b0;
            r_pool_sel <= 1'b0;
            r_err_cfg  <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_state   <= w_next;
            r_err_cfg <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_valid) begin
                        if (w_cfg_bad) begin
                            r_err_cfg <= 1'b1;
                        end else begin
                            r_row_base <= bus.cfg_base;
                            r_wpr      <= bus.cfg_wpr;
                            r_rows     <= bus.cfg_rows;
                            r_size     <= bus.cfg_size;
                            r_pool_sel <= bus.cfg_pool_sel;
                            r_col      <= '0;
                            r_grp      <= '0;
                        end
                    end
                end
                S_START: begin
                    r_addr <= w_beat0_addr + w_wpr_ext;
                    r_beat <= '0;
                end
                S_FEED: begin
                    r_beat <= r_beat + 2'd1;
                    r_addr <= r_addr + w_wpr_ext;
                    r_tmo  <= '0;
                end
                S_WAIT: begin
                    r_tmo <= r_tmo + c_tmo_w'(1);
                    if (bus.done)
                        r_out_data <= r_size ? {{(2*DATA_W){1'b0}}, bus.pool_o[2*DATA_W-1:0]}
                                             : bus.pool_o;
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        if (w_last_col) begin
                            r_col      <= '0;
                            r_grp      <= r_grp + DIM_W'(1);
                            r_row_base <= r_row_base + w_kwpr;
                        end else begin
                            r_col <= r_col + DIM_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Every output is forced low while reset is held, whatever state is left over
    assign bus.cfg_ready = !rst_fsm && !w_busy;
    assign bus.mem_re    = !rst_fsm && w_mem_re;
    assign bus.mem_addr  = rst_fsm ? '0 : ((r_state == S_START) ? w_beat0_addr : r_addr);
    assign bus.start     = !rst_fsm && w_start;
    assign bus.en        = !rst_fsm && w_en;
    assign bus.pool_d    = (!rst_fsm && w_en) ? bus.mem_rdata : '0;
    assign bus.size1     = !rst_fsm && w_busy && !r_size;
    assign bus.size2     = !rst_fsm && w_busy && r_size;
    assign bus.pool_sel  = !rst_fsm && r_pool_sel;
    assign bus.out_valid = !rst_fsm && w_emit;
    assign bus.out_data  = rst_fsm ? '0 : r_out_data;
    assign bus.out_cnt   = (!rst_fsm && w_emit) ? (r_size ? 3'd2 : 3'd4) : 3'd0;
    assign bus.out_last  = !rst_fsm && w_emit && w_last_win;
    assign bus.busy      = !rst_fsm && w_busy;
    assign bus.err       = !rst_fsm && (r_err_cfg || w_tmo);
endmodule
`default_nettype wire

// File: tb/tb_avr_pool_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_avr_pool_sched
// Brief    : Self-checking bench for avr_pool_sched with memory/pool models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avr_pool_sched;
    localparam int DATA_W = 16, ADDR_W = 12, DIM_W = 8, DONE_TMO = 64;

    typedef struct {
        logic [11:0] base;
        logic [7:0]  wpr;
        logic [7:0]  rows;
        logic        size;
        logic        psel;
        int          dly;
        logic        exp_err;
        int          exp_win;
    } vec_t;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  cnt;
        logic        last;
    } out_t;

    logic clk = 1'b0;
    logic rst_fsm = 1'b1;
    always #5 clk = ~clk;

    avr_pool_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

    avr_pool_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .DONE_TMO(DONE_TMO)) dut (
        .clk     (clk),
        .rst_fsm (rst_fsm),
        .bus     (bus)
    );

    int checks = 0, failures = 0;
    logic [127:0] mem [0:4095];
    vec_t tv [9];

    // controls written by the main sequence only
    logic exp_size = 1'b0, exp_psel = 1'b0, done_on = 1'b1, junk_on = 1'b0;
    int   done_dly = 2, ready_mode = 0;

    // observations written by the monitor only
    logic [11:0]  obs_addr [$];
    logic [127:0] obs_pd [$];
    out_t         obs_out [$];
    int cyc = 0, acc_cyc = 0, err_cyc = 0, wait_cyc = 0;
    int n_start = 0, n_err = 0, n_busy = 0;
    int v_rst = 0, v_pdz = 0, v_size = 0, v_quiet = 0, v_stable = 0;

    // pool results issued by the pool model
    logic [63:0] po_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // line memory: read data one cycle after mem_re, junk otherwise
    always @(posedge clk)
        bus.mem_rdata <= bus.mem_re ? mem[bus.mem_addr] : {$urandom, $urandom, $urandom, $urandom};

    // pooling unit model and result consumer
    always begin : pool_model
        int   pend;
        logic prev_en;
        logic fire;
        logic [63:0] po;
        pend = 0; prev_en = 1'b0;
        bus.done = 1'b0; bus.pool_o = '0; bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            fire = 1'b0;
            bus.done = 1'b0;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 2) != 0);
                default: bus.out_ready = 1'b0;
            endcase
            if (rst_fsm) begin
                pend = 0; prev_en = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) fire = 1'b1;
                end else if (prev_en && !bus.en && done_on) begin
                    if (done_dly <= 1) fire = 1'b1;
                    else pend = done_dly - 1;
                end
                if (fire) begin
                    po = {$urandom, $urandom};
                    bus.pool_o = po;
                    bus.done = 1'b1;
                    po_q.push_back(po);
                end else if (junk_on && bus.en) begin
                    bus.done = 1'b1;
                    bus.pool_o = {$urandom, $urandom};
                end
                prev_en = bus.en;
            end
        end
    end

    // monitor: records events and counts invariant violations
    always @(negedge clk) begin : monitor
        logic        m_prev_en, stall;
        logic [63:0] h_data;
        logic [3:0]  h_ctl;
        cyc++;
        if (rst_fsm) begin
            if (|{bus.cfg_ready, bus.mem_re, bus.mem_addr, bus.start, bus.en, bus.size1, bus.size2,
                  bus.pool_sel, bus.pool_d, bus.out_valid, bus.out_data, bus.out_cnt, bus.out_last,
                  bus.busy, bus.err})
                v_rst++;
            m_prev_en = 1'b0; stall = 1'b0;
        end else begin
            if (bus.cfg_valid && bus.cfg_ready) acc_cyc = cyc;
            if (bus.mem_re) obs_addr.push_back(bus.mem_addr);
            if (bus.en) obs_pd.push_back(bus.pool_d);
            else if (bus.pool_d != '0) v_pdz++;
            if (bus.start) n_start++;
            if (bus.err) begin n_err++; err_cyc = cyc; end
            if (bus.busy) n_busy++;
            if (m_prev_en && !bus.en && bus.busy) wait_cyc = cyc;
            m_prev_en = bus.en;
            if ({bus.size2, bus.size1} != (bus.busy ? (exp_size ? 2'b10 : 2'b01) : 2'b00)) v_size++;
            if (bus.busy && bus.pool_sel != exp_psel) v_size++;
            if (bus.out_valid && (bus.start || bus.mem_re)) v_quiet++;
            if (stall && (!bus.out_valid || bus.out_data != h_data || {bus.out_cnt, bus.out_last} != h_ctl))
                v_stable++;
            stall  = bus.out_valid && !bus.out_ready;
            h_data = bus.out_data;
            h_ctl  = {bus.out_cnt, bus.out_last};
            if (bus.out_valid && bus.out_ready)
                obs_out.push_back('{data: bus.out_data, cnt: bus.out_cnt, last: bus.out_last});
        end
    end

    int sn_a, sn_p, sn_o, sn_po, sn_st, sn_err, sn_busy, sn_v;

    task automatic launch(input vec_t v);
        sn_a = obs_addr.size(); sn_p = obs_pd.size(); sn_o = obs_out.size(); sn_po = po_q.size();
        sn_st = n_start; sn_err = n_err; sn_busy = n_busy;
        sn_v = v_pdz + v_size + v_quiet + v_stable;
        exp_size = v.size; exp_psel = v.psel; done_dly = v.dly;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b1; bus.cfg_base = v.base; bus.cfg_wpr = v.wpr;
        bus.cfg_rows = v.rows; bus.cfg_size = v.size; bus.cfg_pool_sel = v.psel;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0; bus.cfg_pool_sel = ~v.psel; bus.cfg_size = ~v.size;
    endtask

    task automatic finish_job(input vec_t v);
        int k, nw, n, w;
        logic [11:0] a;
        logic [63:0] po;
        k = v.size ? 4 : 2;
        for (int t = 0; t < 4000; t++) begin
            if (!bus.busy) break;
            @(posedge clk); #1;
        end
        chk("job_end", bus.busy, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        chk("err_count", n_err - sn_err, v.exp_err);
        chk("start_count", n_start - sn_st, v.exp_win);
        chk("out_count", obs_out.size() - sn_o, v.exp_win);
        chk("re_count", obs_addr.size() - sn_a, v.exp_win * k);
        if (v.exp_err) begin
            chk("err_latency", err_cyc - acc_cyc, 1);
            chk("busy_illegal", n_busy - sn_busy, 0);
        end else begin
            n = 0; w = 0;
            nw = (int'(v.wpr) * int'(v.rows)) / k;
            for (int g = 0; g < int'(v.rows) / k; g++) begin
                for (int c = 0; c < int'(v.wpr); c++) begin
                    for (int j = 0; j < k; j++) begin
                        a = 12'(int'(v.base) + (g * k + j) * int'(v.wpr) + c);
                        if (sn_a + n < obs_addr.size()) chk("addr", obs_addr[sn_a + n], a);
                        if (sn_p + n < obs_pd.size()) chk("beat_data", obs_pd[sn_p + n], mem[a]);
                        n++;
                    end
                    if (sn_o + w < obs_out.size() && sn_po + w < po_q.size()) begin
                        po = po_q[sn_po + w];
                        if (v.size) po[63:32] = '0;
                        chk("out_data", obs_out[sn_o + w].data, po);
                        chk("out_cnt", obs_out[sn_o + w].cnt, v.size ? 3'd2 : 3'd4);
                        chk("out_last", obs_out[sn_o + w].last, (w == nw - 1));
                    end
                    w++;
                end
            end
        end
        chk("invariants", v_pdz + v_size + v_quiet + v_stable - sn_v, 0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin : main
        logic [11:0] t1_addr [4];
        logic [11:0] t2_addr [4];
        logic [63:0] d0;
        vec_t rv;
        int   e0, st0, o0;
        t1_addr = '{12'h010, 12'h012, 12'h011, 12'h013};
        t2_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        //          base     wpr    rows   sz    ps    dly err   win
        tv[0] = '{12'h010, 8'd2, 8'd2, 1'b0, 1'b0, 2, 1'b0, 2};
        tv[1] = '{12'hFFE, 8'd1, 8'd4, 1'b1, 1'b1, 1, 1'b0, 1};
        tv[2] = '{12'h020, 8'd2, 8'd3, 1'b0, 1'b0, 1, 1'b1, 0};
        tv[3] = '{12'h030, 8'd0, 8'd2, 1'b0, 1'b1, 1, 1'b1, 0};
        tv[4] = '{12'h040, 8'd3, 8'd0, 1'b1, 1'b0, 1, 1'b1, 0};
        tv[5] = '{12'h050, 8'd2, 8'd6, 1'b1, 1'b0, 1, 1'b1, 0};
        tv[6] = '{12'h100, 8'd3, 8'd8, 1'b1, 1'b1, 3, 1'b0, 6};
        tv[7] = '{12'h200, 8'd4, 8'd2, 1'b0, 1'b1, 4, 1'b0, 4};
        tv[8] = '{12'hFFF, 8'd2, 8'd4, 1'b0, 1'b0, 1, 1'b0, 4};
        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        bus.cfg_valid = 1'b0; bus.cfg_base = '0; bus.cfg_wpr = '0; bus.cfg_rows = '0;
        bus.cfg_size = 1'b0; bus.cfg_pool_sel = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", |{bus.cfg_ready, bus.mem_re, bus.start, bus.en, bus.out_valid,
                               bus.busy, bus.err, bus.size1, bus.size2}, 1'b0);
        rst_fsm = 1'b0;
        #1;
        chk("cfg_ready_after_reset", bus.cfg_ready, 1'b1);
        chk("busy_after_reset", bus.busy, 1'b0);

        // directed table
        for (int i = 0; i < 9; i++) begin
            launch(tv[i]);
            finish_job(tv[i]);
            if (i == 0)
                for (int j = 0; j < 4; j++)
                    if (sn_a + j < obs_addr.size()) chk("t1_addr", obs_addr[sn_a + j], t1_addr[j]);
            if (i == 1) begin
                for (int j = 0; j < 4; j++)
                    if (sn_a + j < obs_addr.size()) chk("t2_addr", obs_addr[sn_a + j], t2_addr[j]);
                if (sn_o < obs_out.size()) chk("t2_lanes34", obs_out[sn_o].data[63:32], 32'h0);
            end
        end

        // backpressure: consumer holds out_ready low in EMIT
        ready_mode = 2;
        launch(tv[0]);
        for (int t = 0; t < 50; t++) begin
            if (bus.out_valid) break;
            @(posedge clk); #1;
        end
        chk("bp_valid", bus.out_valid, 1'b1);
        d0 = bus.out_data;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", bus.out_valid, 1'b1);
            chk("bp_hold_data", bus.out_data, d0);
            chk("bp_quiet", {bus.start, bus.mem_re}, 2'b00);
        end
        ready_mode = 0;
        finish_job(tv[0]);

        // done never returned: timeout abort
        done_on = 1'b0;
        launch(tv[0]);
        e0 = n_err; st0 = n_start; o0 = obs_out.size();
        for (int t = 0; t < 300; t++) begin
            if (n_err != e0) break;
            @(posedge clk); #1;
        end
        chk("tmo_err", n_err - e0, 1);
        chk("tmo_latency", err_cyc - wait_cyc, DONE_TMO);
        chk("tmo_cfg_ready", bus.cfg_ready, 1'b1);
        chk("tmo_no_output", obs_out.size() - o0, 0);
        chk("tmo_one_window", n_start - st0, 1);
        done_on = 1'b1;

        // reset during FEED of window 1, then a clean rerun
        launch(tv[0]);
        for (int t = 0; t < 100; t++) begin
            if (n_start - sn_st == 2 && bus.en) break;
            @(posedge clk); #1;
        end
        chk("rst_in_feed", bus.en, 1'b1);
        e0 = v_rst;
        rst_fsm = 1'b1;
        #1;
        chk("rst_outputs_zero", |{bus.cfg_ready, bus.mem_re, bus.mem_addr, bus.start, bus.en,
                                  bus.pool_d, bus.out_valid, bus.out_data, bus.busy, bus.err}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_fsm = 1'b0;
        #1;
        chk("rst_monitor", v_rst - e0, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 1'b1);
        launch(tv[0]);
        finish_job(tv[0]);

        // randomized legal jobs against the reference model
        ready_mode = 1;
        for (int i = 0; i < 12; i++) begin
            rv.size    = 1'($urandom_range(0, 1));
            rv.wpr     = 8'($urandom_range(1, 4));
            rv.rows    = 8'((rv.size ? 4 : 2) * $urandom_range(1, 3));
            rv.base    = 12'($urandom);
            rv.psel    = 1'($urandom_range(0, 1));
            rv.dly     = $urandom_range(1, 4);
            rv.exp_err = 1'b0;
            rv.exp_win = int'(rv.wpr) * int'(rv.rows) / (rv.size ? 4 : 2);
            junk_on    = 1'($urandom_range(0, 1));
            launch(rv);
            finish_job(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
